// File: rtl/player_motion.sv
// Per-frame player update: turns button input into a new position and heading, with wall and bounds checks.
// Optional macro COLLISION_EN enables wall checks against the map ROM; without it only the bounds check applies.
module player_motion #(
    parameter int MAP_W         = 16,
    parameter int MAP_H         = 16,
    parameter int MAP_AW        = 8,
    parameter int CELL_SHIFT    = 4,
    parameter int MOVE_STEP     = 4,
    parameter int START_X       = 40,
    parameter int START_Y       = 40,
    parameter int START_HEADING = 0
) (
    input  logic                     clock50Mhz,
    input  logic                     reset,
    input  logic                     clock60hz,
    input  logic                     btn_fwd,
    input  logic                     btn_back,
    input  logic                     btn_left,
    input  logic                     btn_right,
    input  logic                     map_wall,
    output logic [MAP_AW-1:0]        map_addr,
    output logic signed [12:0]       playerX,
    output logic signed [12:0]       playerY,
    output logic signed [9:0]        angle_X,
    output logic signed [9:0]        angle_Y,
    output logic                     update_valid
);

    typedef enum logic [2:0] {
        S_IDLE, S_TURN, S_CALC, S_CHKX, S_WAITX, S_CHKY, S_WAITY, S_DONE
    } state_t;

    localparam logic signed [12:0] X_LIM  = 13'(MAP_W << CELL_SHIFT);
    localparam logic signed [12:0] Y_LIM  = 13'(MAP_H << CELL_SHIFT);
    localparam logic signed [12:0] STEP   = 13'(MOVE_STEP);
    localparam logic signed [12:0] HALF   = 13'sd64;

    // Q1.7 cosine over the first quadrant, index k = 0..16 in 5.625 degree steps
    function automatic logic signed [8:0] quarter(input logic [4:0] k);
        case (k)
            5'd0:    return 9'sd128;
            5'd1:    return 9'sd127;
            5'd2:    return 9'sd126;
            5'd3:    return 9'sd122;
            5'd4:    return 9'sd118;
            5'd5:    return 9'sd113;
            5'd6:    return 9'sd106;
            5'd7:    return 9'sd99;
            5'd8:    return 9'sd91;
            5'd9:    return 9'sd81;
            5'd10:   return 9'sd71;
            5'd11:   return 9'sd60;
            5'd12:   return 9'sd49;
            5'd13:   return 9'sd37;
            5'd14:   return 9'sd25;
            5'd15:   return 9'sd13;
            default: return 9'sd0;
        endcase
    endfunction

    function automatic logic signed [8:0] cos_lut(input logic [5:0] h);
        logic [4:0] m;
        m = {1'b0, h[3:0]};
        case (h[5:4])
            2'd0:    return quarter(m);
            2'd1:    return -quarter(5'd16 - m);
            2'd2:    return -quarter(m);
            default: return quarter(5'd16 - m);
        endcase
    endfunction

    function automatic logic signed [9:0] deg_int(input logic [5:0] h);
        logic [11:0] t;
        t = 12'(h) * 12'd45;
        return 10'(t >> 3);
    endfunction

    function automatic logic signed [9:0] deg_frac(input logic [5:0] h);
        logic [14:0] t;
        t = 15'(h) * 15'd320;
        return {1'b0, t[8:0]};
    endfunction

    state_t state, state_next;
    logic   phase;
    logic   [2:0] sync;
    logic   tick;

    logic do_turn, do_prod, do_delta, do_chkx, do_accx, do_chky, do_accy, do_commit;

    logic [5:0]        heading;
    logic signed [12:0] pos_x, pos_y, prod_x, prod_y, dx, dy;
    logic signed [12:0] cand_x, cand_y, cos_e, sin_e;
    logic signed [8:0]  cos_v, sin_v;
    logic               blk_x, blk_y, oob_x, oob_y, wall_hit;
    logic [5:0]         turn;

    // Sync flops reset high so a level already high at reset release is not taken as an edge
    always_ff @(posedge clock50Mhz) begin
        if (reset) sync <= 3'b111;
        else       sync <= {sync[1:0], clock60hz};
    end
    assign tick = sync[1] & ~sync[2];

    always_ff @(posedge clock50Mhz) begin
        if (reset) begin
            state <= S_IDLE;
            phase <= 1'b0;
        end else begin
            state <= state_next;
            phase <= (state_next == state) ? ~phase : 1'b0;
        end
    end

    // CALC, WAITX and WAITY take two cycles each, fixing the pass at 11 cycles after the tick
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (tick) state_next = S_TURN;
            S_TURN:  state_next = S_CALC;
            S_CALC:  if (phase) state_next = S_CHKX;
            S_CHKX:  state_next = S_WAITX;
            S_WAITX: if (phase) state_next = S_CHKY;
            S_CHKY:  state_next = S_WAITY;
            S_WAITY: if (phase) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        do_turn   = 1'b0;
        do_prod   = 1'b0;
        do_delta  = 1'b0;
        do_chkx   = 1'b0;
        do_accx   = 1'b0;
        do_chky   = 1'b0;
        do_accy   = 1'b0;
        do_commit = 1'b0;
        case (state)
            S_TURN:  do_turn   = 1'b1;
            S_CALC:  begin do_prod = ~phase; do_delta = phase; end
            S_CHKX:  do_chkx   = 1'b1;
            S_WAITX: do_accx   = phase;
            S_CHKY:  do_chky   = 1'b1;
            S_WAITY: do_accy   = phase;
            S_DONE:  do_commit = 1'b1;
            default: ;
        endcase
    end

    assign turn  = (btn_right & ~btn_left) ? 6'd1 :
                   (btn_left & ~btn_right) ? 6'h3f : 6'd0;
    assign cos_v = cos_lut(heading);
    assign sin_v = cos_lut(heading - 6'd16);
    assign cos_e = {{4{cos_v[8]}}, cos_v};
    assign sin_e = {{4{sin_v[8]}}, sin_v};

    assign cand_x = pos_x + dx;
    assign cand_y = pos_y + dy;
    assign oob_x  = cand_x[12] || (cand_x >= X_LIM);
    assign oob_y  = cand_y[12] || (cand_y >= Y_LIM);

`ifdef COLLISION_EN
    localparam logic signed [12:0] ROW_W = 13'(MAP_W);
    logic signed [12:0] addr_x_full, addr_y_full;

    // X probe uses the old row; Y probe uses the already-settled X column
    assign addr_x_full = (pos_y >>> CELL_SHIFT) * ROW_W + (cand_x >>> CELL_SHIFT);
    assign addr_y_full = (cand_y >>> CELL_SHIFT) * ROW_W + (pos_x >>> CELL_SHIFT);
    assign wall_hit    = map_wall;

    always_ff @(posedge clock50Mhz) begin
        if (reset)                 map_addr <= '0;
        else if (do_chkx && !oob_x) map_addr <= MAP_AW'(addr_x_full);
        else if (do_chky && !oob_y) map_addr <= MAP_AW'(addr_y_full);
    end
`else
    logic unused_map_wall;
    assign unused_map_wall = map_wall;
    assign wall_hit        = 1'b0;
    assign map_addr        = '0;
`endif

    always_ff @(posedge clock50Mhz) begin
        if (reset) begin
            heading      <= 6'(START_HEADING);
            pos_x        <= 13'(START_X);
            pos_y        <= 13'(START_Y);
            prod_x       <= '0;
            prod_y       <= '0;
            dx           <= '0;
            dy           <= '0;
            blk_x        <= 1'b0;
            blk_y        <= 1'b0;
            playerX      <= 13'(START_X);
            playerY      <= 13'(START_Y);
            angle_X      <= deg_int(6'(START_HEADING));
            angle_Y      <= deg_frac(6'(START_HEADING));
            update_valid <= 1'b0;
        end else begin
            update_valid <= do_commit;
            if (do_turn) heading <= heading + turn;
            if (do_prod) begin
                if (btn_fwd & ~btn_back) begin
                    prod_x <= cos_e * STEP;
                    prod_y <= sin_e * STEP;
                end else if (btn_back & ~btn_fwd) begin
                    prod_x <= -(cos_e * STEP);
                    prod_y <= -(sin_e * STEP);
                end else begin
                    prod_x <= '0;
                    prod_y <= '0;
                end
            end
            if (do_delta) begin
                dx <= (prod_x + HALF) >>> 7;
                dy <= (prod_y + HALF) >>> 7;
            end
            if (do_chkx) blk_x <= oob_x;
            if (do_accx && !blk_x && !wall_hit) pos_x <= cand_x;
            if (do_chky) blk_y <= oob_y;
            if (do_accy && !blk_y && !wall_hit) pos_y <= cand_y;
            if (do_commit) begin
                playerX <= pos_x;
                playerY <= pos_y;
                angle_X <= deg_int(heading);
                angle_Y <= deg_frac(heading);
            end
        end
    end

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: moves, turns, walls, bounds, busy ticks and mid-pass reset.
module tb_player_motion;

`ifdef COLLISION_EN
    localparam bit COL = 1'b1;
`else
    localparam bit COL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, clock60hz, btn_fwd, btn_back, btn_left, btn_right, map_wall;
    logic [7:0] map_addr;
    logic signed [12:0] playerX, playerY;
    logic signed [9:0]  angle_X, angle_Y;
    logic update_valid;

    logic walls [256];
    int n_cmp = 0, n_bad = 0, uv_cnt = 0, lat = 0, mid_x = 0, base;

    player_motion dut (
        .clock50Mhz(clk), .reset(reset), .clock60hz(clock60hz),
        .btn_fwd(btn_fwd), .btn_back(btn_back), .btn_left(btn_left), .btn_right(btn_right),
        .map_wall(map_wall), .map_addr(map_addr),
        .playerX(playerX), .playerY(playerY), .angle_X(angle_X), .angle_Y(angle_Y),
        .update_valid(update_valid)
    );

    always #5 clk = ~clk;

    // Map ROM: data one cycle after the address
    always @(posedge clk) map_wall <= walls[map_addr];
    always @(posedge clk) if (update_valid) uv_cnt <= uv_cnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock60hz rise with the given buttons; lat = posedges from the rise to update_valid
    task automatic frame(input logic f, input logic b, input logic l, input logic r);
        btn_fwd = f; btn_back = b; btn_left = l; btn_right = r;
        @(negedge clk);
        clock60hz = 1'b1;
        lat = 0;
        while (!update_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 6) mid_x = playerX;
        end
        if (lat >= 40) chk("frame_timeout", lat, 13);
        repeat (2) @(negedge clk);
        clock60hz = 1'b0;
        btn_fwd = 0; btn_back = 0; btn_left = 0; btn_right = 0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) walls[i] = 1'b0;
        reset = 1; clock60hz = 0;
        btn_fwd = 0; btn_back = 0; btn_left = 0; btn_right = 0;
        repeat (3) @(negedge clk);
        chk("rst_x", playerX, 40);
        chk("rst_y", playerY, 40);
        chk("rst_ax", angle_X, 0);
        chk("rst_ay", angle_Y, 0);
        chk("rst_uv", update_valid, 0);
        reset = 0;
        repeat (3) @(negedge clk);

        // forward along +X on an open map: 2 sync cycles + 11-cycle pass
        base = uv_cnt;
        frame(1, 0, 0, 0);
        chk("fwd_latency", lat, 13);
        chk("fwd_mid_hold", mid_x, 40);
        chk("fwd_x", playerX, 44);
        chk("fwd_y", playerY, 40);
        chk("fwd_pulses", uv_cnt - base, 1);

        // wall at cell (3,2) blocks the step into x=48
        walls[35] = 1'b1;
        frame(1, 0, 0, 0);
        chk("wall_x", playerX, COL ? 44 : 48);
        chk("wall_y", playerY, 40);
        chk("wall_addr", map_addr, COL ? 34 : 0);

        frame(0, 0, 1, 0);
        chk("left_ax", angle_X, 354);
        chk("left_ay", angle_Y, 192);
        chk("left_x", playerX, COL ? 44 : 48);

        frame(0, 0, 1, 1);
        chk("lr_ax", angle_X, 354);

        frame(0, 0, 0, 1);
        chk("wrap_ax", angle_X, 0);
        chk("wrap_ay", angle_Y, 0);

        for (int i = 0; i < 8; i++) frame(0, 0, 0, 1);
        chk("h8_ax", angle_X, 45);
        chk("h8_ay", angle_Y, 0);

        // diagonal at h=8: dx=dy=3
        frame(1, 0, 0, 0);
        chk("diag_x", playerX, COL ? 47 : 51);
        chk("diag_y", playerY, 43);

        // X blocked by the wall, Y still slides
        frame(1, 0, 0, 0);
        chk("slide_x", playerX, COL ? 47 : 54);
        chk("slide_y", playerY, 46);

        frame(1, 1, 0, 0);
        chk("fb_x", playerX, COL ? 47 : 54);
        chk("fb_y", playerY, 46);

        for (int i = 0; i < 8; i++) frame(0, 0, 1, 0);
        chk("h0_ax", angle_X, 0);

        // backwards along -X until the x<0 bound stops it
        for (int i = 0; i < 14; i++) frame(0, 1, 0, 0);
        chk("bound_x", playerX, COL ? 3 : 2);
        chk("bound_y", playerY, 46);

        // second rise while the pass is busy is dropped
        base = uv_cnt;
        @(negedge clk);
        clock60hz = 1'b1;
        repeat (3) @(negedge clk);
        clock60hz = 1'b0;
        repeat (2) @(negedge clk);
        clock60hz = 1'b1;
        repeat (40) @(negedge clk);
        clock60hz = 1'b0;
        repeat (5) @(negedge clk);
        chk("busy_pulses", uv_cnt - base, 1);

        // reset in the middle of a pass aborts it
        base = uv_cnt;
        btn_fwd = 1'b1;
        clock60hz = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        btn_fwd = 1'b0;
        chk("abort_pulses", uv_cnt - base, 0);
        chk("abort_x", playerX, 40);
        chk("abort_y", playerY, 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
